// File: rtl/frost32_ldst_unit_pkg.sv
// Shared types and decode helpers for the Frost32 load/store unit.
// Optional misalignment trap: FROST32_LDST_MISALIGN_CHECK_EN (uses is_misaligned below).
package frost32_ldst_unit_pkg;

    typedef enum logic [2:0] {
        LDST_LD32  = 3'd0,
        LDST_LDU16 = 3'd1,
        LDST_LDS16 = 3'd2,
        LDST_LDU8  = 3'd3,
        LDST_LDS8  = 3'd4,
        LDST_ST32  = 3'd5,
        LDST_ST16  = 3'd6,
        LDST_ST8   = 3'd7
    } ldst_type_e;

    typedef enum logic [1:0] {
        LDST_IDLE = 2'd0,
        LDST_REQ  = 2'd1,
        LDST_RESP = 2'd2
    } ldst_state_e;

    typedef enum logic [1:0] {
        SIZE_8  = 2'd0,
        SIZE_16 = 2'd1,
        SIZE_32 = 2'd2
    } ldst_size_e;

    typedef struct packed {
        ldst_type_e  ldst_type;
        logic [31:0] addr;
        logic [31:0] st_data;
        logic [3:0]  rd_index;
    } port_in_ldst_unit_s;

    typedef struct packed {
        logic        ld_valid;
        logic [31:0] ld_data;
        logic [3:0]  rd_index;
        logic        misalign;
    } port_out_ldst_unit_s;

    function automatic logic is_load(input ldst_type_e t);
        return (t < LDST_ST32);
    endfunction

    function automatic ldst_size_e ldst_size(input ldst_type_e t);
        ldst_size_e size;
        case (t)
            LDST_LD32, LDST_ST32:              size = SIZE_32;
            LDST_LDU16, LDST_LDS16, LDST_ST16: size = SIZE_16;
            LDST_LDU8, LDST_LDS8, LDST_ST8:    size = SIZE_8;
            default:                           size = SIZE_8;
        endcase
        return size;
    endfunction

    function automatic logic ldst_sign_ext(input ldst_type_e t);
        return (t == LDST_LDS16) || (t == LDST_LDS8);
    endfunction

    function automatic logic is_misaligned(input ldst_type_e t, input logic [1:0] addr_lo);
        logic mis;
        case (ldst_size(t))
            SIZE_32: mis = (addr_lo != 2'b00);
            SIZE_16: mis = addr_lo[0];
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/frost32_ldst_lane_align.sv
// Combinational lane steering: byte enables, store replication and load
// extract/extend for one 32-bit little-endian word.
module frost32_ldst_lane_align
    import frost32_ldst_unit_pkg::*;
(
    input  logic [2:0]  ldst_type,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] rdata,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);

    ldst_type_e type_s;
    ldst_size_e size_s;
    logic       sext_s;
    logic [15:0] half_s;
    logic [7:0]  byte_s;

    assign type_s = ldst_type_e'(ldst_type);
    assign size_s = ldst_size(type_s);
    assign sext_s = ldst_sign_ext(type_s);

    // Pick the addressed half and byte out of the read word.
    always_comb begin
        half_s = 16'h0000;
        byte_s = 8'h00;
        if (addr_lo[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
        case (addr_lo)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
    end

    // Size-dependent lane enables, write replication and load extension.
    always_comb begin
        byte_en = 4'b0000;
        wdata   = 32'h0000_0000;
        ld_data = 32'h0000_0000;
        case (size_s)
            SIZE_32: begin
                byte_en = 4'b1111;
                wdata   = st_data;
                ld_data = rdata;
            end
            SIZE_16: begin
                byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{st_data[15:0]}};
                ld_data = {{16{sext_s & half_s[15]}}, half_s};
            end
            SIZE_8: begin
                byte_en = 4'b0001 << addr_lo;
                wdata   = {4{st_data[7:0]}};
                ld_data = {{24{sext_s & byte_s[7]}}, byte_s};
            end
            default: begin
                byte_en = 4'b0000;
                wdata   = 32'h0000_0000;
                ld_data = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: rtl/frost32_ldst_unit.sv
// Frost32 load/store unit: one single-beat word access at a time, stalls the pipe meanwhile.
// Define FROST32_LDST_MISALIGN_CHECK_EN to trap misaligned 16/32-bit accesses instead of aligning them.
module frost32_ldst_unit
    import frost32_ldst_unit_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 30
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                in_ldst_type,
    input  logic [31:0]               in_addr,
    input  logic [31:0]               in_st_data,
    input  logic [3:0]                in_rd_index,
    output logic                      mem_req,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic                      mem_we,
    output logic [3:0]                mem_byte_en,
    output logic [31:0]               mem_wdata,
    input  logic [31:0]               mem_rdata,
    input  logic                      mem_ack,
    output logic                      out_ld_valid,
    output logic [31:0]               out_ld_data,
    output logic [3:0]                out_rd_index,
    output logic                      out_stall,
    output logic                      out_misalign
);

    port_in_ldst_unit_s  in_op_s;
    port_out_ldst_unit_s out_r;
    ldst_state_e         state_r;
    ldst_state_e         state_next_s;

    logic        accept_s;
    logic        mis_s;
    logic        ack_s;
    logic [2:0]  type_r;
    logic [1:0]  addr_lo_r;
    logic        is_load_r;
    logic [2:0]  align_type_s;
    logic [1:0]  align_lo_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;
    logic [31:0] ld_data_s;

    logic                      mem_req_r;
    logic                      mem_we_r;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_r;
    logic [3:0]                mem_byte_en_r;
    logic [31:0]               mem_wdata_r;

    assign in_op_s = {ldst_type_e'(in_ldst_type), in_addr, in_st_data, in_rd_index};

`ifdef FROST32_LDST_MISALIGN_CHECK_EN
    assign mis_s = is_misaligned(in_op_s.ldst_type, in_op_s.addr[1:0]);
`else
    assign mis_s = 1'b0;
`endif

    assign ack_s     = (state_r == LDST_REQ) && mem_ack;
    assign in_ready  = (state_r == LDST_IDLE);
    assign out_stall = (state_r != LDST_IDLE) || (in_valid && (state_r == LDST_IDLE));

    // While idle the aligner steers the incoming op; afterwards the latched one.
    assign align_type_s = in_ready ? in_ldst_type : type_r;
    assign align_lo_s   = in_ready ? in_addr[1:0] : addr_lo_r;

    frost32_ldst_lane_align u_lane_align (
        .ldst_type (align_type_s),
        .addr_lo   (align_lo_s),
        .st_data   (in_op_s.st_data),
        .rdata     (mem_rdata),
        .byte_en   (be_s),
        .wdata     (wdata_s),
        .ld_data   (ld_data_s)
    );

    // Next-state decode; a misaligned op skips the memory and reports in RESP.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            LDST_IDLE: begin
                if (in_valid) begin
                    accept_s     = 1'b1;
                    state_next_s = mis_s ? LDST_RESP : LDST_REQ;
                end else begin
                    state_next_s = LDST_IDLE;
                end
            end
            LDST_REQ: begin
                if (mem_ack) begin
                    state_next_s = is_load_r ? LDST_RESP : LDST_IDLE;
                end else begin
                    state_next_s = LDST_REQ;
                end
            end
            LDST_RESP: state_next_s = LDST_IDLE;
            default:   state_next_s = LDST_IDLE;
        endcase
    end

    // State, latched operation and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= LDST_IDLE;
            type_r        <= 3'd0;
            addr_lo_r     <= 2'd0;
            is_load_r     <= 1'b0;
            mem_req_r     <= 1'b0;
            mem_we_r      <= 1'b0;
            mem_addr_r    <= '0;
            mem_byte_en_r <= 4'b0000;
            mem_wdata_r   <= 32'h0000_0000;
            out_r         <= '0;
        end else begin
            state_r         <= state_next_s;
            mem_req_r       <= (state_next_s == LDST_REQ);
            out_r.ld_valid  <= ack_s && is_load_r;
            out_r.misalign  <= accept_s && mis_s;
            if (accept_s) begin
                type_r         <= in_ldst_type;
                addr_lo_r      <= in_addr[1:0];
                is_load_r      <= is_load(in_op_s.ldst_type);
                mem_we_r       <= !is_load(in_op_s.ldst_type) && !mis_s;
                mem_addr_r     <= in_op_s.addr[MEM_ADDR_WIDTH+1:2];
                mem_byte_en_r  <= be_s;
                mem_wdata_r    <= wdata_s;
                out_r.rd_index <= in_op_s.rd_index;
            end else if (state_next_s != LDST_REQ) begin
                mem_we_r <= 1'b0;
            end
            if (ack_s && is_load_r) begin
                out_r.ld_data <= ld_data_s;
            end
        end
    end

    assign mem_req      = mem_req_r;
    assign mem_we       = mem_we_r;
    assign mem_addr     = mem_addr_r;
    assign mem_byte_en  = mem_byte_en_r;
    assign mem_wdata    = mem_wdata_r;
    assign out_ld_valid = out_r.ld_valid;
    assign out_ld_data  = out_r.ld_data;
    assign out_rd_index = out_r.rd_index;
    assign out_misalign = out_r.misalign;

endmodule

// File: tb/tb_frost32_ldst_unit.sv
// Self-checking bench for frost32_ldst_unit: directed table, hand sequences and random ops vs. a reference model.
module tb_frost32_ldst_unit;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_ldst_type;
    logic [31:0] in_addr;
    logic [31:0] in_st_data;
    logic [3:0]  in_rd_index;
    logic        mem_req;
    logic [29:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        out_ld_valid;
    logic [31:0] out_ld_data;
    logic [3:0]  out_rd_index;
    logic        out_stall;
    logic        out_misalign;

    int n_chk;
    int n_fail;

    frost32_ldst_unit #(.MEM_ADDR_WIDTH(30)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_ldst_type (in_ldst_type),
        .in_addr      (in_addr),
        .in_st_data   (in_st_data),
        .in_rd_index  (in_rd_index),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_byte_en  (mem_byte_en),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .out_ld_valid (out_ld_valid),
        .out_ld_data  (out_ld_data),
        .out_rd_index (out_rd_index),
        .out_stall    (out_stall),
        .out_misalign (out_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  t;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  rd;
        logic [31:0] rdata;
        int          waits;
        logic [31:0] exp_data;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model (type codes: 0 Ld32 .. 4 LdS8, 5 St32, 6 St16, 7 St8)
    function automatic int m_size(input logic [2:0] t);
        if (t == 3'd0 || t == 3'd5) return 4;
        if (t == 3'd1 || t == 3'd2 || t == 3'd6) return 2;
        return 1;
    endfunction

    function automatic bit m_is_ld(input logic [2:0] t);
        return t < 3'd5;
    endfunction

    function automatic bit m_misal(input logic [2:0] t, input logic [31:0] a);
`ifdef FROST32_LDST_MISALIGN_CHECK_EN
        return (a % 32'd4) % m_size(t) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] m_ld(input logic [2:0] t, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] v;
        int sz;
        sz = m_size(t);
        if (sz == 4) return w;
        if (sz == 2) begin
            v = (w >> (16 * ((a / 32'd2) % 32'd2))) & 32'h0000_FFFF;
            if (t == 3'd2 && v >= 32'h0000_8000) v = v + 32'hFFFF_0000;
        end else begin
            v = (w >> (8 * (a % 32'd4))) & 32'h0000_00FF;
            if (t == 3'd4 && v >= 32'h0000_0080) v = v + 32'hFFFF_FF00;
        end
        return v;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] t, input logic [31:0] a);
        int sz;
        int lane;
        sz   = m_size(t);
        lane = int'((a % 32'd4) / 32'(sz)) * sz;
        return 4'(((1 << sz) - 1) << lane);
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] t, input logic [31:0] d);
        int sz;
        sz = m_size(t);
        if (sz == 4) return d;
        if (sz == 2) return (d & 32'h0000_FFFF) * 32'h0001_0001;
        return (d & 32'h0000_00FF) * 32'h0101_0101;
    endfunction

    // Issue one op, serve it from the bench memory after 'waits' cycles, check everything.
    task automatic run_op(input string tag, input logic [2:0] t, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] rd, input logic [31:0] rdata,
                          input int waits, input logic [31:0] exp_data,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) chk({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_ldst_type = t; in_addr = a; in_st_data = d; in_rd_index = rd;
        #1;
        chk({tag, "_stall_accept"}, 32'(out_stall), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_st_data = $urandom;
        @(negedge clk);
        if (m_misal(t, a)) begin
            chk({tag, "_mis_noreq"}, 32'(mem_req), 32'd0);
            chk({tag, "_mis_pulse"}, 32'(out_misalign), 32'd1);
            chk({tag, "_mis_novalid"}, 32'(out_ld_valid), 32'd0);
            @(negedge clk);
            chk({tag, "_mis_end"}, 32'(out_misalign), 32'd0);
            chk({tag, "_mis_ready"}, 32'(in_ready), 32'd1);
            return;
        end
        chk({tag, "_req"}, 32'(mem_req), 32'd1);
        chk({tag, "_addr"}, 32'(mem_addr), a >> 2);
        chk({tag, "_we"}, 32'(mem_we), 32'(!m_is_ld(t)));
        chk({tag, "_be"}, 32'(mem_byte_en), 32'(exp_be));
        if (!m_is_ld(t)) chk({tag, "_wdata"}, mem_wdata, exp_wd);
        chk({tag, "_busy"}, 32'(in_ready), 32'd0);
        for (int w = 0; w < waits; w++) begin
            @(negedge clk);
            chk({tag, "_req_hold"}, 32'(mem_req), 32'd1);
            chk({tag, "_be_hold"}, 32'(mem_byte_en), 32'(exp_be));
        end
        mem_ack = 1'b1; mem_rdata = rdata;
        @(posedge clk);
        #1;
        mem_ack = 1'b0; mem_rdata = $urandom;
        @(negedge clk);
        if (m_is_ld(t)) begin
            chk({tag, "_ld_valid"}, 32'(out_ld_valid), 32'd1);
            chk({tag, "_ld_data"}, out_ld_data, exp_data);
            chk({tag, "_rd"}, 32'(out_rd_index), 32'(rd));
            chk({tag, "_resp_busy"}, 32'(in_ready), 32'd0);
            chk({tag, "_resp_nomis"}, 32'(out_misalign), 32'd0);
            @(negedge clk);
            chk({tag, "_ld_pulse_end"}, 32'(out_ld_valid), 32'd0);
        end else begin
            chk({tag, "_st_novalid"}, 32'(out_ld_valid), 32'd0);
            chk({tag, "_st_noreq"}, 32'(mem_req), 32'd0);
        end
        chk({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    endtask

    vec_t tbl[10];

    initial begin
        logic [2:0]  rt;
        logic [31:0] ra;
        logic [31:0] rdv;
        logic [31:0] rw;
        logic [3:0]  rr;

        n_chk = 0; n_fail = 0;
        reset_n = 1'b0; in_valid = 1'b0; in_ldst_type = 3'd0; in_addr = 32'h0;
        in_st_data = 32'h0; in_rd_index = 4'd0; mem_rdata = 32'h0; mem_ack = 1'b0;

        tbl[0] = '{3'd0, 32'h0000_1004, 32'h0, 4'd5,  32'hDEAD_BEEF, 2, 32'hDEAD_BEEF, 4'b1111, 32'h0};
        tbl[1] = '{3'd4, 32'h0000_2003, 32'h0, 4'd1,  32'h8012_3456, 0, 32'hFFFF_FF80, 4'b1000, 32'h0};
        tbl[2] = '{3'd3, 32'h0000_2003, 32'h0, 4'd2,  32'h8012_3456, 1, 32'h0000_0080, 4'b1000, 32'h0};
        tbl[3] = '{3'd2, 32'h0000_3002, 32'h0, 4'd3,  32'h8001_5555, 0, 32'hFFFF_8001, 4'b1100, 32'h0};
        tbl[4] = '{3'd1, 32'h0000_3000, 32'h0, 4'd4,  32'h8001_7FFF, 3, 32'h0000_7FFF, 4'b0011, 32'h0};
        tbl[5] = '{3'd7, 32'h0000_4001, 32'h1234_56AB, 4'd6, 32'h0, 1, 32'h0, 4'b0010, 32'hABAB_ABAB};
        tbl[6] = '{3'd6, 32'h0000_4002, 32'h1111_BEEF, 4'd7, 32'h0, 0, 32'h0, 4'b1100, 32'hBEEF_BEEF};
        tbl[7] = '{3'd5, 32'h0000_4000, 32'hCAFE_F00D, 4'd8, 32'h0, 2, 32'h0, 4'b1111, 32'hCAFE_F00D};
        tbl[8] = '{3'd0, 32'h0000_1006, 32'h0, 4'd9,  32'h0102_0304, 0, 32'h0102_0304, 4'b1111, 32'h0};
        tbl[9] = '{3'd4, 32'h0000_2000, 32'h0, 4'd15, 32'h0000_007F, 1, 32'h0000_007F, 4'b0001, 32'h0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_be", 32'(mem_byte_en), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_valid", 32'(out_ld_valid), 32'd0);
        chk("rst_data", out_ld_data, 32'd0);
        chk("rst_rd", 32'(out_rd_index), 32'd0);
        chk("rst_mis", 32'(out_misalign), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_stall", 32'(out_stall), 32'd0);
        reset_n = 1'b1;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("tbl%0d", i), tbl[i].t, tbl[i].a, tbl[i].d, tbl[i].rd, tbl[i].rdata,
                   tbl[i].waits, tbl[i].exp_data, tbl[i].exp_be, tbl[i].exp_wdata);
        end

        // Back-to-back with zero-wait memory: St32 then Ld32, in_valid held high
        @(negedge clk);
        in_valid = 1'b1; in_ldst_type = 3'd5; in_addr = 32'h0000_0100; in_st_data = 32'h5A5A_0001; in_rd_index = 4'd3;
        @(posedge clk);
        #1;
        in_ldst_type = 3'd0; in_addr = 32'h0000_0200; in_rd_index = 4'd11;
        @(negedge clk);
        chk("b2b_st_req", 32'(mem_req), 32'd1);
        chk("b2b_st_busy", 32'(in_ready), 32'd0);
        chk("b2b_st_stall", 32'(out_stall), 32'd1);
        chk("b2b_st_addr", 32'(mem_addr), 32'h40);
        mem_ack = 1'b1;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("b2b_idle_ready", 32'(in_ready), 32'd1);
        chk("b2b_idle_stall", 32'(out_stall), 32'd1);
        chk("b2b_idle_noreq", 32'(mem_req), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_ld_req", 32'(mem_req), 32'd1);
        chk("b2b_ld_addr", 32'(mem_addr), 32'h80);
        chk("b2b_ld_we", 32'(mem_we), 32'd0);
        chk("b2b_ld_stall", 32'(out_stall), 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h7654_3210;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("b2b_ld_valid", 32'(out_ld_valid), 32'd1);
        chk("b2b_ld_data", out_ld_data, 32'h7654_3210);
        chk("b2b_ld_rd", 32'(out_rd_index), 32'd11);
        chk("b2b_resp_stall", 32'(out_stall), 32'd1);
        @(negedge clk);
        chk("b2b_done_stall", 32'(out_stall), 32'd0);

        // Random ops against the model
        for (int i = 0; i < 60; i++) begin
            rt  = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rw  = $urandom;
            rdv = $urandom;
            rr  = 4'($urandom);
            run_op($sformatf("rnd%0d", i), rt, ra, rw, rr, rdv, $urandom_range(0, 3),
                   m_ld(rt, ra, rdv), m_be(rt, ra), m_wd(rt, rw));
        end

        // Reset while in REQ, then a stray ack after release
        @(negedge clk);
        in_valid = 1'b1; in_ldst_type = 3'd7; in_addr = 32'h0000_5009; in_st_data = 32'h0000_00C3; in_rd_index = 4'd9;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rreq_pre_req", 32'(mem_req), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rreq_req", 32'(mem_req), 32'd0);
        chk("rreq_we", 32'(mem_we), 32'd0);
        chk("rreq_be", 32'(mem_byte_en), 32'd0);
        chk("rreq_addr", 32'(mem_addr), 32'd0);
        chk("rreq_wdata", mem_wdata, 32'd0);
        chk("rreq_data", out_ld_data, 32'd0);
        chk("rreq_rd", 32'(out_rd_index), 32'd0);
        chk("rreq_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("stray_novalid", 32'(out_ld_valid), 32'd0);
        chk("stray_noreq", 32'(mem_req), 32'd0);
        chk("stray_ready", 32'(in_ready), 32'd1);
        chk("stray_data", out_ld_data, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/frost32_ldst_unit.md
# frost32_ldst_unit

Load/store unit for the Frost32 pipeline, downstream of the instruction decoder and execute stage. It takes one decoded load/store operation at a time: the decoder's `LdstType` code, an effective address, store data and a destination register index. It drives a single-beat 32-bit word-addressed data memory handshake. For loads it returns a zero- or sign-extended result with its destination register index. While an access is in flight it holds the pipeline stall request.

## Interface
Parameters:
- `MEM_ADDR_WIDTH`, default 30: width of the word address driven to memory (byte address bits [31:2]).

Ports:
- `clk`  in  1  pipeline clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  an operation is presented.
- `in_ready`  out  1  unit can accept; transfer occurs when `in_valid && in_ready`.
- `in_ldst_type`  in  3  `PkgInstrDecoder::LdstType` code (Ld32..St8).
- `in_addr`  in  32  byte effective address (rb + rc or rb + simm12, computed upstream).
- `in_st_data`  in  32  store data (ra value); ignored for loads.
- `in_rd_index`  in  4  load destination register.
- `mem_req`  out  1  memory request.
- `mem_addr`  out  MEM_ADDR_WIDTH  word address = `in_addr[31:2]`.
- `mem_we`  out  1  1 = store.
- `mem_byte_en`  out  4  byte lane enables; lane n = bits [8n+7:8n], little-endian.
- `mem_wdata`  out  32  store data replicated onto the addressed lanes.
- `mem_rdata`  in  32  read data, valid when `mem_ack`.
- `mem_ack`  in  1  one-cycle completion pulse.
- `out_ld_valid`  out  1  one-cycle pulse: load result valid.
- `out_ld_data`  out  32  extended load result.
- `out_rd_index`  out  4  register index of `out_ld_data`.
- `out_stall`  out  1  pipeline stall request.
- `out_misalign`  out  1  one-cycle misalignment pulse (only with the macro; tied 0 otherwise).

## Operation
- FSM states are IDLE, REQ and RESP.
- IDLE: `in_ready`=1. On accept, the unit latches type, address, data and rd, and goes to REQ.
- REQ: `mem_req`=1 and all `mem_*` outputs are held stable. On `mem_ack`:
  - a load latches `mem_rdata` and goes to RESP;
  - a store goes to IDLE with no output pulse.
- RESP: `out_ld_valid`=1 for exactly one cycle, then IDLE.
- Byte enables: 32-bit access → 4'b1111; 16-bit access → 4'b0011 << (2·addr[1]); 8-bit access → 4'b0001 << addr[1:0].
- Store data: St16 replicates `st_data[15:0]` onto both halves; St8 replicates `st_data[7:0]` onto all four lanes.
- Load extraction: select the addressed half/byte. LdU* zero-extends, LdS* sign-extends from bit 15 or bit 7, Ld32 passes the word through.
- `out_stall` = (state != IDLE) || (in_valid && state == IDLE), which asserts combinationally in the accept cycle.
- Reset (asynchronous, any state): state=IDLE, and `mem_req`, `mem_we`, `out_ld_valid`, `out_misalign` are all 0. `mem_byte_en`, `mem_addr`, `mem_wdata`, `out_ld_data` and `out_rd_index` are 0. Any in-flight access is abandoned, and a late `mem_ack` arriving in IDLE is ignored.

## Timing
- Accept at edge N → `mem_req` high from cycle N+1.
- `mem_ack` sampled at edge M → for a load, `out_ld_valid` is high in cycle M+1; for a store, `in_ready` is high in cycle M+1.
- Minimum load latency is 3 cycles from accept to result; minimum store occupancy is 2 cycles.
- `mem_ack` in the same cycle `mem_req` first rises is legal (zero-wait memory).
- The unit accepts no new operation before returning to IDLE, so back-to-back operations cost one IDLE cycle each.

## Configuration
- `FROST32_LDST_MISALIGN_CHECK_EN` defined:
  - A 32-bit access with addr[1:0]≠0, or a 16-bit access with addr[0]=1, is accepted but never requested.
  - The FSM goes IDLE→RESP with `out_misalign`=1 and `out_ld_valid`=0, then returns to IDLE.
- Not defined: no check. The low address bits are forced to natural alignment (16-bit uses addr[1] only, 32-bit ignores addr[1:0]), and `out_misalign` is tied 0.

## Structure
- Add to `PkgInstrDecoder`:
  - a `LdstState` enum (IDLE/REQ/RESP);
  - the `is_load` (type < St32), access-size and sign-extend decode functions;
  - a packed `PortIn_LdstUnit` / `PortOut_LdstUnit` struct pair, matching `PortOut_InstrDecoder` style.
- One sub-module, `frost32_ldst_lane_align`: purely combinational byte-enable generation, store replication and load extract/extend, so it is reusable by a future cache.

## Test plan
- Ld32 @0x0000_1004, `mem_rdata`=0xDEAD_BEEF, ack after 2 waits → `mem_addr`=0x401, `mem_byte_en`=4'b1111, `out_ld_data`=0xDEAD_BEEF, rd preserved, `out_ld_valid` one cycle.
- LdS8 @…03 with rdata 0x80xx_xxxx → 0xFFFF_FF80; LdU8 on the same data → 0x0000_0080; LdS16 @…02 with rdata 0x8001_xxxx → 0xFFFF_8001.
- St8 @…01, data 0x1234_56AB → `mem_we`=1, `mem_byte_en`=4'b0010, `mem_wdata`=0xABAB_ABAB, no `out_ld_valid`, `in_ready` high the cycle after ack.
- Zero-wait ack plus back-to-back valid operations → `in_ready` low through REQ/RESP, second operation accepted only in IDLE, `out_stall` continuous.
- Assert `reset_n`=0 while in REQ, then ack after release → all outputs 0 immediately, stray ack ignored, no `out_ld_valid`.
- With the macro, Ld32 @…02 → no `mem_req`, `out_misalign` pulses once; without the macro → `mem_byte_en`=4'b1111, normal completion.
